operand_fetch: RTL

- ID-stage reader for the 32x32 register file in the MIPS pipeline.
- Decodes register fields from the incoming instruction and drives the register file's two combinational read addresses.
- Resolves RAW hazards by bypassing from EX, MEM and WB, and inserts one bubble on load-use.
- Registers the resolved operands into the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fwd_mux.sv | 32 +++
 rtl/operand_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the ID stage: instruction field positions,
// opcodes, and the operand-fetch stall state.
package mips_pkg;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_W   = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    typedef enum logic {RUN, BUBBLE} of_state_e;

    // Only these opcodes actually read rt; everything else uses rt as a destination or not at all.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: youngest matching writer wins, register 0 is hardwired to zero.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              ex_en_i,
    input  logic [ADDR_W-1:0] ex_adr_i,
    input  logic [DATA_W-1:0] ex_val_i,
    input  logic              mem_en_i,
    input  logic [ADDR_W-1:0] mem_adr_i,
    input  logic [DATA_W-1:0] mem_val_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_val_i,
    input  logic [DATA_W-1:0] rf_val_i,
    output logic [DATA_W-1:0] val_o
);

    always_comb begin
        val_o = rf_val_i;
        if (adr_i == '0)
            val_o = '0;
        else if (ex_en_i && ex_adr_i == adr_i)
            val_o = ex_val_i;
        else if (mem_en_i && mem_adr_i == adr_i)
            val_o = mem_val_i;
        else if (wb_en_i && wb_adr_i == adr_i)
            val_o = wb_val_i;
    end

endmodule

// File: rtl/operand_fetch.sv
// ID-stage operand fetch: register-file read, EX/MEM/WB bypass, load-use bubble,
// and the ID/EX pipeline register with valid/ready handshake.
module operand_fetch
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_adr1,
    output logic [ADDR_W-1:0] rf_adr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_wr_adr,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_wr_adr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_adr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [ADDR_W-1:0] out_rs,
    output logic [ADDR_W-1:0] out_rt,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [31:0]       out_pc
);

    logic [ADDR_W-1:0] rs, rt, rd;
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_val, rt_val, imm_sx;
    logic              ex_fwd_en, load_use, adv, accept;
    of_state_e         state_q, state_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] rs_val_q, rt_val_q, imm_q;
    logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [31:0]       pc_q;

    assign opcode  = instr[OPC_LSB +: 6];
    assign rs      = instr[RS_LSB +: ADDR_W];
    assign rt      = instr[RT_LSB +: ADDR_W];
    assign rd      = instr[RD_LSB +: ADDR_W];
    assign imm_sx  = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign rf_adr1 = rs;
    assign rf_adr2 = rt;

    // A load in EX has no data yet, so it is never a bypass source; it stalls instead.
    assign ex_fwd_en = ex_wr_en & ~ex_is_load;
    assign load_use  = in_valid & ex_wr_en & ex_is_load & (ex_wr_adr != '0) &
                       ((ex_wr_adr == rs) | (uses_rt(opcode) & (ex_wr_adr == rt)));

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = rst & ~flush & ~load_use & adv;
    assign accept   = in_valid & in_ready;

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
        .adr_i(rs), .ex_en_i(ex_fwd_en), .ex_adr_i(ex_wr_adr), .ex_val_i(ex_result),
        .mem_en_i(mem_wr_en), .mem_adr_i(mem_wr_adr), .mem_val_i(mem_result),
        .wb_en_i(wb_wr_en), .wb_adr_i(wb_wr_adr), .wb_val_i(wb_data),
        .rf_val_i(rf_data1), .val_o(rs_val)
    );

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
        .adr_i(rt), .ex_en_i(ex_fwd_en), .ex_adr_i(ex_wr_adr), .ex_val_i(ex_result),
        .mem_en_i(mem_wr_en), .mem_adr_i(mem_wr_adr), .mem_val_i(mem_result),
        .wb_en_i(wb_wr_en), .wb_adr_i(wb_wr_adr), .wb_val_i(wb_data),
        .rf_val_i(rf_data2), .val_o(rt_val)
    );

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = RUN;
        else if (load_use && adv)
            state_d = BUBBLE;
        else if (!load_use)
            state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (adv) begin
                // Not accepting while EX drains means a bubble (load-use or idle IF/ID).
                out_valid_q <= accept;
                if (accept) begin
                    rs_val_q <= rs_val;
                    rt_val_q <= rt_val;
                    rs_q     <= rs;
                    rt_q     <= rt;
                    rd_q     <= rd;
                    imm_q    <= imm_sx;
                    pc_q     <= pc;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_rs_val = rs_val_q;
    assign out_rt_val = rt_val_q;
    assign out_rs     = rs_q;
    assign out_rt     = rt_q;
    assign out_rd     = rd_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;

endmodule
